// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit slice reused over WIDTH/4 cycles with a registered inter-nibble carry.
// Optional signed-overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = $clog2(NIB) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] a_shift_s, b_shift_s;
  logic [3:0]       a_nib_s, b_nib_s;
  logic             carry_in_s;
  logic [4:0]       nib_sum_s;
  logic [3:0]       low3_sum_s;
  logic             ovf_s;
  logic             last_s;
  logic [IDX_W+1:0] shamt_s;

  // Slice datapath: select nibble idx_q of the latched operands and add with the running carry.
  always_comb begin
    shamt_s    = {idx_q, 2'b00};
    a_shift_s  = a_q >> shamt_s;
    b_shift_s  = b_q >> shamt_s;
    a_nib_s    = a_shift_s[3:0];
    b_nib_s    = b_shift_s[3:0];
    carry_in_s = (idx_q == {IDX_W{1'b0}}) ? cin_q : carry_q;
    nib_sum_s  = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'b0000, carry_in_s};
    // Carry into the MSB bit comes from the low three bits of the top nibble.
    low3_sum_s = {1'b0, a_nib_s[2:0]} + {1'b0, b_nib_s[2:0]} + {3'b000, carry_in_s};
    ovf_s      = low3_sum_s[3] ^ nib_sum_s[4];
    last_s     = (idx_q == IDX_W'(NIB - 1));
  end

  // Controller next-state and register updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          sum_d   = {WIDTH{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~(NIB_MASK << shamt_s)) | (WIDTH'(nib_sum_s[3:0]) << shamt_s);
        carry_d = nib_sum_s[4];
        idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        if (last_s) begin
          cout_d      = nib_sum_s[4];
          ovf_d       = ovf_s;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d == S_RUN) || (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      cin_q       <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= {IDX_W{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: vector table at WIDTH=16 plus handshake, reset and WIDTH=4 sequences.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
  logic        ovf;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] a4 = 4'h0;
  logic [3:0] b4 = 4'h0;
  logic       cin4 = 1'b0;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [3:0] sum4;
  logic       cout4;
  logic       busy4;
  logic       ovf4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait for the result, return latency in cycles after the accept edge.
  task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vc, output int lat);
    a = va; b = vb; cin = vc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] held;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[9] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sum", 32'(sum), 32'h0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'd1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
      tick();
      check($sformatf("vec%0d out_valid pulse", i), 32'(out_valid), 32'd0);
      check($sformatf("vec%0d back idle", i), 32'(in_ready), 32'd1);
      check($sformatf("vec%0d sum held", i), 32'(sum), 32'(vecs[i].exp_sum));
    end

    // Reset on the second RUN cycle discards the operation (cout is 1 from the last vector).
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst sum", 32'(sum), 32'h0);
    check("rst cout", 32'(cout), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst no result", 32'(out_valid), 32'd0);
    end
    launch(16'h0F0F, 16'h0101, 1'b0, lat);
    check("post-rst latency", 32'(lat), 32'd4);
    check("post-rst sum", 32'(sum), 32'h1010);
    check("post-rst cout", 32'(cout), 32'd0);
    tick();

    // Back-pressure in DONE with an ignored in_valid.
    out_ready = 1'b0;
    launch(16'h00F0, 16'h0010, 1'b0, lat);
    check("bp latency", 32'(lat), 32'd4);
    held = sum;
    a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp busy", 32'(busy), 32'd1);
      check("bp sum", 32'(sum), 32'h0100);
    end
    check("bp sum stable", 32'(sum), 32'(held));
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release busy", 32'(busy), 32'd0);
    check("bp release sum", 32'(sum), 32'h0100);
    tick();
    tick();
    check("bp no extra op", 32'(busy), 32'd0);

    // WIDTH=4 instance: single-cycle run.
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    check("w4 not yet valid", 32'(out_valid4), 32'd0);
    check("w4 busy", 32'(busy4), 32'd1);
    tick();
    check("w4 out_valid", 32'(out_valid4), 32'd1);
    check("w4 sum", 32'(sum4), 32'h1);
    check("w4 cout", 32'(cout4), 32'd1);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("w4 ovf", 32'(ovf4), 32'd1);
`endif
    tick();
    check("w4 idle", 32'(in_ready4), 32'd1);
    check("w4 out_valid drop", 32'(out_valid4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
